// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: one load/store port and two instruction-fetch
// ports share a single 8-bit memory. Load/store wins; fetch ports round-robin.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [2:0]            ls_size,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  input  logic                  if0_req,
  input  logic                  if1_req,
  input  logic [ADDR_WIDTH-1:0] if0_addr,
  input  logic [ADDR_WIDTH-1:0] if1_addr,
  output logic                  if0_done,
  output logic                  if1_done,
  output logic [31:0]           if_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_LS, OWN_IF0, OWN_IF1} owner_t;

  function automatic logic [2:0] size_decode(input logic [2:0] size);
    case (size)
      3'd1:    size_decode = 3'd1;
      3'd2:    size_decode = 3'd2;
      default: size_decode = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [2:0] idx);
    case (idx)
      3'd0:    byte_sel = word[7:0];
      3'd1:    byte_sel = word[15:8];
      3'd2:    byte_sel = word[23:16];
      3'd3:    byte_sel = word[31:24];
      default: byte_sel = 8'd0;
    endcase
  endfunction

  function automatic logic [31:0] byte_ins(input logic [31:0] word, input logic [2:0] idx,
                                           input logic [7:0] b);
    byte_ins = word;
    case (idx)
      3'd0:    byte_ins[7:0]   = b;
      3'd1:    byte_ins[15:8]  = b;
      3'd2:    byte_ins[23:16] = b;
      3'd3:    byte_ins[31:24] = b;
      default: byte_ins = word;
    endcase
  endfunction

  state_t                r_state, w_state_nxt;
  owner_t                r_owner, w_owner_nxt;
  logic [2:0]            r_k, w_k_nxt;
  logic [2:0]            r_n, w_n_nxt;
  logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
  logic [31:0]           r_wdata, w_wdata_nxt;
  logic [31:0]           r_asm, w_asm_nxt;
  logic                  r_last_if0, w_last_if0_nxt;
  logic [7:0]            r_din_hold;
  logic                  r_hold_vld;
  logic [ADDR_WIDTH-1:0] r_mem_a, w_mem_a_nxt;
  logic [7:0]            r_mem_dout, w_mem_dout_nxt;
  logic                  r_mem_wr, w_mem_wr_nxt;
  logic                  r_ls_done, w_ls_done_nxt;
  logic                  r_if0_done, w_if0_done_nxt;
  logic                  r_if1_done, w_if1_done_nxt;
  logic [31:0]           r_ls_rdata, w_ls_rdata_nxt;
  logic [31:0]           r_if_rdata, w_if_rdata_nxt;
  logic [7:0]            w_din;
  logic [2:0]            w_kidx;
  logic [ADDR_WIDTH-1:0] w_k_ext;

  // The byte answering the address of the last active cycle arrives in the
  // first paused cycle; keep it so a resumed read captures the right byte.
  assign w_din   = r_hold_vld ? r_din_hold : mem_din;
  assign w_kidx  = r_k - 3'd1;
  assign w_k_ext = {{(ADDR_WIDTH-3){1'b0}}, w_k_nxt};

  // Next-state, arbitration and byte assembly
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_k_nxt        = r_k;
    w_n_nxt        = r_n;
    w_base_nxt     = r_base;
    w_wdata_nxt    = r_wdata;
    w_asm_nxt      = r_asm;
    w_last_if0_nxt = r_last_if0;
    case (r_state)
      S_IDLE: begin
        if (ls_req) begin
          w_owner_nxt = OWN_LS;
          w_base_nxt  = ls_addr;
          w_n_nxt     = size_decode(ls_size);
          w_wdata_nxt = ls_wdata;
          w_k_nxt     = 3'd0;
          w_asm_nxt   = 32'd0;
          w_state_nxt = ls_we ? S_WRITE : S_READ;
        end else if (if0_req && (!if1_req || !r_last_if0)) begin
          w_owner_nxt    = OWN_IF0;
          w_base_nxt     = if0_addr;
          w_n_nxt        = 3'd4;
          w_k_nxt        = 3'd0;
          w_asm_nxt      = 32'd0;
          w_last_if0_nxt = 1'b1;
          w_state_nxt    = S_READ;
        end else if (if1_req) begin
          w_owner_nxt    = OWN_IF1;
          w_base_nxt     = if1_addr;
          w_n_nxt        = 3'd4;
          w_k_nxt        = 3'd0;
          w_asm_nxt      = 32'd0;
          w_last_if0_nxt = 1'b0;
          w_state_nxt    = S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (r_k != 3'd0) begin
          w_asm_nxt = byte_ins(r_asm, w_kidx, w_din);
        end else begin
          w_asm_nxt = r_asm;
        end
        if (r_k >= r_n) begin
          w_k_nxt     = 3'd0;
          w_state_nxt = S_DONE;
        end else begin
          w_k_nxt = r_k + 3'd1;
        end
      end
      S_WRITE: begin
        if (r_k >= r_n - 3'd1) begin
          w_k_nxt     = 3'd0;
          w_state_nxt = S_DONE;
        end else begin
          w_k_nxt = r_k + 3'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = 3'd0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    w_mem_a_nxt    = '0;
    w_mem_dout_nxt = 8'd0;
    w_mem_wr_nxt   = 1'b0;
    w_ls_done_nxt  = 1'b0;
    w_if0_done_nxt = 1'b0;
    w_if1_done_nxt = 1'b0;
    w_ls_rdata_nxt = r_ls_rdata;
    w_if_rdata_nxt = r_if_rdata;
    if (w_state_nxt == S_WRITE) begin
      w_mem_a_nxt    = w_base_nxt + w_k_ext;
      w_mem_dout_nxt = byte_sel(w_wdata_nxt, w_k_nxt);
      w_mem_wr_nxt   = 1'b1;
    end else if (w_state_nxt == S_READ && w_k_nxt < w_n_nxt) begin
      w_mem_a_nxt = w_base_nxt + w_k_ext;
    end else begin
      w_mem_a_nxt = '0;
    end
    if (w_state_nxt == S_DONE) begin
      case (w_owner_nxt)
        OWN_LS:  w_ls_done_nxt  = 1'b1;
        OWN_IF0: w_if0_done_nxt = 1'b1;
        OWN_IF1: w_if1_done_nxt = 1'b1;
        default: w_ls_done_nxt  = 1'b0;
      endcase
    end else begin
      w_ls_done_nxt = 1'b0;
    end
    if (r_state == S_READ && w_state_nxt == S_DONE) begin
      if (r_owner == OWN_LS) begin
        w_ls_rdata_nxt = w_asm_nxt;
      end else begin
        w_if_rdata_nxt = w_asm_nxt;
      end
    end else begin
      w_ls_rdata_nxt = r_ls_rdata;
    end
  end

  // Main state and output registers; rdy=0 freezes them all
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_LS;
      r_k        <= 3'd0;
      r_n        <= 3'd4;
      r_base     <= '0;
      r_wdata    <= 32'd0;
      r_asm      <= 32'd0;
      r_last_if0 <= 1'b0;
      r_mem_a    <= '0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_ls_done  <= 1'b0;
      r_if0_done <= 1'b0;
      r_if1_done <= 1'b0;
      r_ls_rdata <= 32'd0;
      r_if_rdata <= 32'd0;
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_k        <= w_k_nxt;
      r_n        <= w_n_nxt;
      r_base     <= w_base_nxt;
      r_wdata    <= w_wdata_nxt;
      r_asm      <= w_asm_nxt;
      r_last_if0 <= w_last_if0_nxt;
      r_mem_a    <= w_mem_a_nxt;
      r_mem_dout <= w_mem_dout_nxt;
      r_mem_wr   <= w_mem_wr_nxt;
      r_ls_done  <= w_ls_done_nxt;
      r_if0_done <= w_if0_done_nxt;
      r_if1_done <= w_if1_done_nxt;
      r_ls_rdata <= w_ls_rdata_nxt;
      r_if_rdata <= w_if_rdata_nxt;
    end else begin
      r_state <= r_state;
    end
  end

  // Capture of the in-flight read byte at the start of a pause
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_din_hold <= 8'd0;
      r_hold_vld <= 1'b0;
    end else if (!rdy && !r_hold_vld) begin
      r_din_hold <= mem_din;
      r_hold_vld <= 1'b1;
    end else if (rdy) begin
      r_hold_vld <= 1'b0;
    end else begin
      r_hold_vld <= r_hold_vld;
    end
  end

  assign mem_a    = r_mem_a;
  assign mem_dout = r_mem_dout;
  assign mem_wr   = r_mem_wr & rdy;
  assign ls_done  = r_ls_done;
  assign if0_done = r_if0_done;
  assign if1_done = r_if1_done;
  assign ls_rdata = r_ls_rdata;
  assign if_rdata = r_if_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 32, width of all address ports and address arithmetic.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 rdy  input  1  global enable; 0 = pause (see REQ-021).
REQ-005 ls_req  input  1  load/store request, held with ls_we/ls_addr/ls_size/ls_wdata stable until ls_done.
REQ-006 ls_we  input  1  1 = write, 0 = read.
REQ-007 ls_addr  input  ADDR_WIDTH  byte address of first byte.
REQ-008 ls_size  input  3  byte count: 1, 2 or 4; any other value is treated as 4.
REQ-009 ls_wdata  input  32  write data, little-endian, byte k = bits [8k+7:8k].
REQ-010 ls_done  output  1  one-cycle completion pulse.
REQ-011 ls_rdata  output  32  read result, zero-extended, held until next ls read completes.
REQ-012 if0_req / if1_req  input  1 each  instruction-fetch requests, always 4-byte reads, held until own done.
REQ-013 if0_addr / if1_addr  input  ADDR_WIDTH each  fetch addresses.
REQ-014 if0_done / if1_done  output  1 each  one-cycle completion pulses.
REQ-015 if_rdata  output  32  fetched word; valid in the cycle if0_done or if1_done is 1; held until the next fetch completes.
REQ-016 mem_din  input  8  memory read byte; carries the byte addressed by mem_a in the previous cycle.
REQ-017 mem_dout  output  8  memory write byte.
REQ-018 mem_a  output  ADDR_WIDTH  memory byte address.
REQ-019 mem_wr  output  1  1 = write mem_dout to mem_a this cycle, 0 = read.

Function
REQ-020 FSM states: IDLE, READ, WRITE, DONE; counter k (3 bits), latched owner, size N, base address, assembly register.
REQ-021 rdy=0 freezes every register (state, k, outputs) except mem_wr, which is driven 0; the operation resumes unchanged on rdy=1.
REQ-022 IDLE: arbitrate on the sampled requests; ls_req has highest priority; between if0_req and if1_req a round-robin pointer grants the one not granted last, with if0 favoured after reset.
REQ-023 Grant at edge: latch owner, address, N (4 for fetch) and write data, set k=0, go to WRITE if ls_we=1 and owner=ls, else READ; update the round-robin pointer only on fetch grants.
REQ-024 IDLE with no request: mem_a=0, mem_wr=0, state unchanged.
REQ-025 READ with k<N: mem_a=base+k, mem_wr=0; address arithmetic wraps modulo 2^ADDR_WIDTH.
REQ-026 READ edge with k>=1: capture mem_din into assembly byte k-1; k increments.
REQ-027 READ with k=N: mem_a=0, capture final byte, go to DONE.
REQ-028 WRITE with k<N: mem_a=base+k, mem_dout=wdata byte k, mem_wr=1; go to DONE after k=N-1.
REQ-029 DONE: for one cycle, pulse the owner's done, present rdata (reads only; bytes >= N are 0), mem_wr=0, no arbitration; next state IDLE.
REQ-030 Requesters deassert or change req in the cycle after done; a req held high is treated as a new request.
REQ-031 Latency from request sampled in cycle t (arbiter idle, rdy=1): read N bytes -> done at t+N+2; write N bytes -> done at t+N+1.
REQ-032 Requests arriving while busy wait; no request is dropped; at most one done pulse is asserted per cycle.

Reset
REQ-033 rst=0 asynchronously forces IDLE, k=0, pointer to if0, and mem_a=0, mem_dout=0, mem_wr=0, all done outputs 0, ls_rdata=0, if_rdata=0.
REQ-034 Reset mid-operation discards the partial transfer; the requester re-issues after reset release.

Verification
REQ-035 if0 fetch 0x100, memory bytes 0x13,0x05,0x10,0x00 -> mem_a sequence 0x100..0x103, if0_done at t+6, if_rdata=0x00100513.
REQ-036 ls write size 2, addr 0x30004, wdata 0xAABBCCDD -> mem_wr=1 at 0x30004 (0xDD) then 0x30005 (0xCC), ls_done at t+3, no further writes.
REQ-037 ls read, if0 and if1 all requested in the same cycle -> ls served first, then if0, then if1; three done pulses in distinct cycles.
REQ-038 if0 and if1 continuously re-requesting -> grants alternate if0, if1, if0 ...
REQ-039 rdy=0 for 3 cycles during a 4-byte read at k=2 -> mem_a held, mem_wr=0, result identical to the unpaused read, done delayed by exactly 3 cycles.
REQ-040 rst asserted during a write at k=1 -> outputs zero immediately, state IDLE, no done pulse; a new request after release completes normally.
